// File: rtl/mem_wb_stage.sv
// ============================================================================
// mem_wb_stage : memory/writeback stage -- req/gnt/rvalid data bus, byte-lane
// alignment, load extension, register-file writeback and upstream stall.
// Optional macro MISALIGN_TRAP_EN: trap misaligned half/word accesses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter int XLEN         = 32,
  parameter int WB_PC_OFFSET = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [4:0]      waddr_i,
  input  logic            reg_write_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      wb_sel_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_be_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            rf_we_o,
  output logic [4:0]      rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            stall_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_t;

  state_t state, next_state;

  logic            access;
  logic            go;
  logic            trap;
  logic [1:0]      off;
  logic [1:0]      lane_off;
  logic            is_byte;
  logic            is_half;
  logic            is_word;
  logic            is_unsigned;
  logic            req;
  logic            stall;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_data;

  assign access      = mem_read_i | mem_write_i;
  assign off         = alu_result_i[1:0];
  // Reserved size codes (011, 110, 111) fall through to a full word.
  assign is_byte     = (funct3_i[1:0] == 2'b00);
  assign is_half     = (funct3_i[1:0] == 2'b01);
  assign is_word     = ~is_byte & ~is_half;
  assign is_unsigned = funct3_i[2];

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (is_half & off[0]) | (is_word & (off != 2'b00));
  assign trap       = access & misaligned;
  assign lane_off   = off;
`else
  assign trap       = 1'b0;
  assign lane_off   = is_word ? 2'b00 : (is_half ? {off[1], 1'b0} : off);
`endif

  assign go = access & ~trap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    req        = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE, REQ: begin
        if (go) begin
          req = 1'b1;
          if (!dmem_gnt_i) begin
            stall      = 1'b1;
            next_state = REQ;
          end else if (mem_read_i) begin
            stall      = 1'b1;
            next_state = WAIT_R;
          end else begin
            next_state = IDLE;
          end
        end else begin
          next_state = IDLE;
        end
      end
      WAIT_R: begin
        if (dmem_rvalid_i) begin
          next_state = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign dmem_req_o  = req & rst;
  assign stall_o     = stall & rst;
  assign misalign_o  = trap & rst;
  assign dmem_we_o   = mem_write_i;
  assign dmem_addr_o = {alu_result_i[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = store_data_i;
    if (is_byte) begin
      dmem_be_o    = 4'b0001 << lane_off;
      dmem_wdata_o = {(XLEN/8){store_data_i[7:0]}};
    end else if (is_half) begin
      dmem_be_o    = 4'b0011 << lane_off;
      dmem_wdata_o = {(XLEN/16){store_data_i[15:0]}};
    end
  end

  assign shifted = dmem_rdata_i >> {lane_off, 3'b000};

  always_comb begin
    load_data = shifted;
    if (is_byte) begin
      load_data = {{(XLEN-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
    end else if (is_half) begin
      load_data = {{(XLEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
    end
  end

  always_comb begin
    rf_wdata_o = '0;
    case (wb_sel_i)
      2'd0:    rf_wdata_o = alu_result_i;
      2'd1:    rf_wdata_o = load_data;
      2'd2:    rf_wdata_o = pc_i + XLEN'(WB_PC_OFFSET);
      default: rf_wdata_o = '0;
    endcase
  end

  // Loads stall until their rvalid cycle, so ~stall alone times their write.
  assign rf_we_o    = rst & reg_write_i & (waddr_i != 5'd0) & ~stall & ~trap;
  assign rf_waddr_o = waddr_i;

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// tb_mem_wb_stage : randomized self-checking bench for mem_wb_stage against a
// transaction-level model of bus timing, lane placement and writeback.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, alu_result_i, store_data_i;
  logic [4:0]  waddr_i;
  logic        reg_write_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [1:0]  wb_sel_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        stall_o, misalign_o;

  mem_wb_stage #(.XLEN(32), .WB_PC_OFFSET(4)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i), .waddr_i(waddr_i), .reg_write_i(reg_write_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .wb_sel_i(wb_sel_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .stall_o(stall_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expected outputs for the current cycle, set by the driver.
  logic        chk_en = 1'b0;
  logic        e_req, e_we, e_stall, e_mis, e_rfwe;
  logic [31:0] e_addr, e_wdata, e_rfwdata;
  logic [3:0]  e_be;
  logic [4:0]  e_waddr;

  // Observation counters, owned by the compare process.
  int          cnt_req = 0, cnt_stall = 0, cnt_rfwe = 0, cnt_mis = 0;
  logic [31:0] last_rfwdata = 0, last_addr = 0, last_wdata = 0;
  logic [3:0]  last_be = 0;
  int          b_req, b_stall, b_rfwe, b_mis;

  logic        fix_rdata_en = 1'b0;
  logic [31:0] fix_rdata = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("req", 32'(dmem_req_o), 32'(e_req));
      check("stall", 32'(stall_o), 32'(e_stall));
      check("misalign", 32'(misalign_o), 32'(e_mis));
      check("rf_we", 32'(rf_we_o), 32'(e_rfwe));
      if (e_req) begin
        check("addr", dmem_addr_o, e_addr);
        check("we", 32'(dmem_we_o), 32'(e_we));
        if (e_we) begin
          check("be", 32'(dmem_be_o), 32'(e_be));
          check("wdata", dmem_wdata_o, e_wdata);
        end
      end
      if (e_rfwe) begin
        check("rf_waddr", 32'(rf_waddr_o), 32'(e_waddr));
        check("rf_wdata", rf_wdata_o, e_rfwdata);
      end
      cnt_req   += int'(dmem_req_o);
      cnt_stall += int'(stall_o);
      cnt_mis   += int'(misalign_o);
      if (rf_we_o) begin
        cnt_rfwe++;
        last_rfwdata = rf_wdata_o;
      end
      if (dmem_req_o) begin
        last_addr  = dmem_addr_o;
        last_be    = dmem_be_o;
        last_wdata = dmem_wdata_o;
      end
    end
  end

  // ---------------- behavioural model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int nat_off(input logic [31:0] a, input logic [2:0] f3);
    int o = int'(a[1:0]);
    return o - (o % size_of(f3));
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] rd, input logic [2:0] f3,
                                             input logic [31:0] a);
    logic [31:0] v = rd >> (8 * nat_off(a, f3));
    if (size_of(f3) == 1) begin
      v = v % 32'd256;
      if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
    end else if (size_of(f3) == 2) begin
      v = v % 32'd65536;
      if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic logic [3:0] be_model(input logic [31:0] a, input logic [2:0] f3);
    return 4'(((1 << size_of(f3)) - 1) << nat_off(a, f3));
  endfunction

  function automatic logic [31:0] wdata_model(input logic [31:0] sd, input logic [2:0] f3);
    if (size_of(f3) == 1) return (sd % 32'd256) * 32'h0101_0101;
    if (size_of(f3) == 2) return (sd % 32'd65536) * 32'h0001_0001;
    return sd;
  endfunction

  task automatic snap();
    b_req = cnt_req; b_stall = cnt_stall; b_rfwe = cnt_rfwe; b_mis = cnt_mis;
  endtask

  task automatic zero_exp();
    e_req = 0; e_we = 0; e_stall = 0; e_mis = 0; e_rfwe = 0;
    e_addr = 0; e_wdata = 0; e_rfwdata = 0; e_be = 0; e_waddr = 0;
  endtask

  // Called at posedge+1; runs one instruction to completion. g = cycles before
  // gnt, r = empty WAIT_R cycles before rvalid.
  task automatic run_instr(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] wa, input logic rw, input logic mr, input logic mw,
                           input logic [2:0] f3, input logic [1:0] ws, input int g, input int r);
    logic acc, misal, trapped, go;
    int   nc;
    pc_i = pc; alu_result_i = alu; store_data_i = sd; waddr_i = wa;
    reg_write_i = rw; mem_read_i = mr; mem_write_i = mw; funct3_i = f3; wb_sel_i = ws;
    acc     = mr | mw;
    misal   = (int'(alu[1:0]) % size_of(f3)) != 0;
    trapped = TRAP && acc && misal;
    go      = acc && !trapped;
    nc      = !go ? 1 : (mr ? g + r + 2 : g + 1);
    for (int k = 0; k < nc; k++) begin
      dmem_gnt_i   = go && (k == g);
      dmem_rdata_i = fix_rdata_en ? fix_rdata : $urandom;
      if (go && mr && k > g) dmem_rvalid_i = (k == g + r + 1);
      else                   dmem_rvalid_i = 1'($urandom % 2);
      e_req     = go && (k <= g);
      e_we      = mw;
      e_addr    = alu & 32'hFFFF_FFFC;
      e_be      = be_model(alu, f3);
      e_wdata   = wdata_model(sd, f3);
      e_stall   = go && (k < nc - 1);
      e_mis     = trapped;
      e_rfwe    = rw && (wa != 0) && (k == nc - 1) && !trapped;
      e_waddr   = wa;
      case (ws)
        2'd0:    e_rfwdata = alu;
        2'd1:    e_rfwdata = load_model(dmem_rdata_i, f3, alu);
        2'd2:    e_rfwdata = pc + 32'd4;
        default: e_rfwdata = 32'd0;
      endcase
      chk_en = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
    end
  endtask

  logic [1:0] ws_pick [3] = '{2'd0, 2'd2, 2'd3};

  initial begin
    rst = 1'b0;
    pc_i = 32'h40; alu_result_i = 32'h100; store_data_i = 0; waddr_i = 5'd5;
    reg_write_i = 1; mem_read_i = 1; mem_write_i = 0; funct3_i = 3'd2; wb_sel_i = 2'd1;
    dmem_gnt_i = 1; dmem_rvalid_i = 1; dmem_rdata_i = 0;
    zero_exp();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;

    // ALU writeback, zero latency; then x0 suppressed.
    snap();
    run_instr(32'h40, 32'h1234, 0, 5'd5, 1, 0, 0, 3'd0, 2'd0, 0, 0);
    check("alu_wdata_lit", last_rfwdata, 32'h0000_1234);
    check("alu_we_count", 32'(cnt_rfwe - b_rfwe), 32'd1);
    check("alu_stall_count", 32'(cnt_stall - b_stall), 32'd0);
    snap();
    run_instr(32'h40, 32'h1234, 0, 5'd0, 1, 0, 0, 3'd0, 2'd0, 0, 0);
    check("x0_we_count", 32'(cnt_rfwe - b_rfwe), 32'd0);

    // LB / LBU at 0x103.
    fix_rdata_en = 1'b1; fix_rdata = 32'h80AA_BBCC;
    snap();
    run_instr(32'h44, 32'h103, 0, 5'd6, 1, 1, 0, 3'd0, 2'd1, 0, 0);
    check("lb_wdata_lit", last_rfwdata, 32'hFFFF_FF80);
    check("lb_stall_count", 32'(cnt_stall - b_stall), 32'd1);
    run_instr(32'h48, 32'h103, 0, 5'd6, 1, 1, 0, 3'd4, 2'd1, 0, 0);
    check("lbu_wdata_lit", last_rfwdata, 32'h0000_0080);
    fix_rdata_en = 1'b0;

    // SH at 0x102, gnt after 3 cycles.
    snap();
    run_instr(32'h4C, 32'h102, 32'h0000_BEEF, 5'd0, 0, 0, 1, 3'd1, 2'd0, 3, 0);
    check("sh_req_count", 32'(cnt_req - b_req), 32'd4);
    check("sh_stall_count", 32'(cnt_stall - b_stall), 32'd3);
    check("sh_be_lit", 32'(last_be), 32'hC);
    check("sh_wdata_lit", last_wdata, 32'hBEEF_BEEF);
    check("sh_addr_lit", last_addr, 32'h100);

    // LW with rvalid 5 cycles late: exactly one write.
    snap();
    run_instr(32'h50, 32'h200, 0, 5'd9, 1, 1, 0, 3'd2, 2'd1, 0, 5);
    check("lw_stall_count", 32'(cnt_stall - b_stall), 32'd6);
    check("lw_we_count", 32'(cnt_rfwe - b_rfwe), 32'd1);

    // Misaligned LW at 0x101.
    snap();
    run_instr(32'h54, 32'h101, 0, 5'd3, 1, 1, 0, 3'd2, 2'd1, 0, 0);
    if (TRAP) begin
      check("mis_pulse_count", 32'(cnt_mis - b_mis), 32'd1);
      check("mis_req_count", 32'(cnt_req - b_req), 32'd0);
      check("mis_we_count", 32'(cnt_rfwe - b_rfwe), 32'd0);
    end else begin
      check("mask_addr_lit", last_addr, 32'h100);
      check("mask_be_lit", 32'(last_be), 32'hF);
    end

    // Reset during WAIT_R, then a late rvalid must be ignored.
    pc_i = 32'h58; alu_result_i = 32'h300; waddr_i = 5'd7; reg_write_i = 1;
    mem_read_i = 1; mem_write_i = 0; funct3_i = 3'd2; wb_sel_i = 2'd1;
    dmem_gnt_i = 1; dmem_rvalid_i = 0;
    zero_exp(); e_req = 1; e_stall = 1; e_addr = 32'h300;
    @(negedge clk); @(posedge clk); #1;
    dmem_gnt_i = 0; e_req = 0;
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0; zero_exp();
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b1; mem_read_i = 0; reg_write_i = 0; dmem_rvalid_i = 1;
    snap();
    @(negedge clk); @(posedge clk); #1;
    check("post_reset_we_count", 32'(cnt_rfwe - b_rfwe), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int          sel;
      logic [2:0]  f3;
      sel = int'($urandom % 5);
      case (sel)
        0: run_instr($urandom & 32'hFFFF_FFFC, $urandom, $urandom, 5'($urandom),
                     1'($urandom), 0, 0, 3'($urandom), ws_pick[$urandom % 3], 0, 0);
        1, 2: begin
          f3 = 3'($urandom);
          run_instr($urandom & 32'hFFFF_FFFC, $urandom, $urandom, 5'($urandom),
                    1'($urandom), 1, 0, f3, 2'd1, int'($urandom % 4), int'($urandom % 4));
        end
        default: begin
          f3 = 3'($urandom % 3);
          run_instr($urandom & 32'hFFFF_FFFC, $urandom, $urandom, 5'($urandom),
                    0, 0, 1, f3, 2'd0, int'($urandom % 4), 0);
        end
      endcase
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
